// File: rtl/ddr_maint_cmd_seq.sv
// ddr_maint_cmd_seq -- DDR maintenance command sequencer.
//
// Serves refresh and MR0 update requests as all-bank maintenance sequences:
//   refresh : PREA -> (T_RP) -> REF -> (T_RFC) [-> ZQCS -> (T_ZQCS)] -> DONE
//   mrs     : PREA -> (T_RP) -> MRS -> (T_MOD) -> DONE
// Requests are held in sticky pending flags. Refresh wins over MRS when
// both flags are pending. Each sequence is followed by at least one IDLE
// cycle. All command pins are registered, and idle cycles drive DES.
//
// Optional feature: define DDR_MAINT_ZQCS_EN to append ZQCS after every REF.
// Without it, T_ZQCS is ignored.
// Each T_* parameter must lie in 2..1023, because the wait counter is 10 bits.
//
// Ports:
//   clock_t, reset_n        clock, asynchronous active-low reset
//   refresh_rdy             one-cycle refresh request pulse
//   mrs_update_rdy          one-cycle MRS request pulse
//   mrs_update_cmd          MR0 opcode, latched while mrs_update_rdy=1
//   cs_n/act_n/ras_n/cas_n/we_n/bg/ba/addr   registered DDR command bus
//   maint_busy              1 whenever a sequence is in progress
//   maint_done              one-cycle pulse in the DONE state
module ddr_maint_cmd_seq #(
    parameter int unsigned T_RP      = 11,
    parameter int unsigned T_RFC     = 280,
    parameter int unsigned T_MOD     = 24,
    parameter int unsigned T_ZQCS    = 128,
    parameter int unsigned MRS_WIDTH = 18
) (
    input  logic                 clock_t,
    input  logic                 reset_n,
    input  logic                 refresh_rdy,
    input  logic                 mrs_update_rdy,
    input  logic [MRS_WIDTH-1:0] mrs_update_cmd,
    output logic                 cs_n,
    output logic                 act_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic [1:0]           bg,
    output logic [1:0]           ba,
    output logic [17:0]          addr,
    output logic                 maint_busy,
    output logic                 maint_done
);

    typedef enum logic [3:0] {
        IDLE,
        PREA,
        WAIT_RP,
        REF,
        WAIT_RFC,
`ifdef DDR_MAINT_ZQCS_EN
        ZQ,
        WAIT_ZQ,
`endif
        MRS,
        WAIT_MOD,
        DONE
    } state_t;

    // A command cycle holds the count. The wait state then spends (T_x - 1)
    // cycles counting (T_x - 2) down to 0, so the next command lands at +T_x.
    localparam logic [9:0] LD_RP  = 10'(T_RP - 2);
    localparam logic [9:0] LD_RFC = 10'(T_RFC - 2);
    localparam logic [9:0] LD_MOD = 10'(T_MOD - 2);
`ifdef DDR_MAINT_ZQCS_EN
    localparam logic [9:0] LD_ZQ  = 10'(T_ZQCS - 2);
`endif

    state_t               state_q, state_d;
    logic [9:0]           cnt_q, cnt_d;
    logic                 pend_ref_q, pend_mrs_q;
    logic                 clr_ref, clr_mrs;
    logic                 sel_mrs_q, sel_mrs_d;
    logic [MRS_WIDTH-1:0] mrs_op_q;

    logic                 cs_n_d, act_n_d, ras_n_d, cas_n_d, we_n_d;
    logic [1:0]           bg_d, ba_d;
    logic [17:0]          addr_d;

    // Next-state and counter control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_mrs_d = sel_mrs_q;
        clr_ref   = 1'b0;
        clr_mrs   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_ref_q) begin
                    state_d   = PREA;
                    cnt_d     = LD_RP;
                    sel_mrs_d = 1'b0;
                    clr_ref   = 1'b1;
                end else if (pend_mrs_q) begin
                    state_d   = PREA;
                    cnt_d     = LD_RP;
                    sel_mrs_d = 1'b1;
                    clr_mrs   = 1'b1;
                end
            end
            PREA: state_d = WAIT_RP;
            WAIT_RP: begin
                if (cnt_q == '0) begin
                    state_d = sel_mrs_q ? MRS : REF;
                    cnt_d   = sel_mrs_q ? LD_MOD : LD_RFC;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            REF: state_d = WAIT_RFC;
            WAIT_RFC: begin
                if (cnt_q == '0) begin
`ifdef DDR_MAINT_ZQCS_EN
                    state_d = ZQ;
                    cnt_d   = LD_ZQ;
`else
                    state_d = DONE;
`endif
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
`ifdef DDR_MAINT_ZQCS_EN
            ZQ: state_d = WAIT_ZQ;
            WAIT_ZQ: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 10'd1;
            end
`endif
            MRS: state_d = WAIT_MOD;
            WAIT_MOD: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 10'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The command bus is decoded from the next state, so the registered pins
    // change on the same edge the FSM enters the command state.
    always_comb begin
        cs_n_d  = 1'b1;
        act_n_d = 1'b1;
        ras_n_d = 1'b1;
        cas_n_d = 1'b1;
        we_n_d  = 1'b1;
        bg_d    = '0;
        ba_d    = '0;
        addr_d  = '0;
        case (state_d)
            PREA: begin
                cs_n_d     = 1'b0;
                ras_n_d    = 1'b0;
                we_n_d     = 1'b0;
                addr_d[10] = 1'b1;
            end
            REF: begin
                cs_n_d  = 1'b0;
                ras_n_d = 1'b0;
                cas_n_d = 1'b0;
            end
`ifdef DDR_MAINT_ZQCS_EN
            ZQ: begin
                cs_n_d = 1'b0;
                we_n_d = 1'b0;
            end
`endif
            MRS: begin
                cs_n_d  = 1'b0;
                ras_n_d = 1'b0;
                cas_n_d = 1'b0;
                we_n_d  = 1'b0;
                addr_d  = 18'(mrs_op_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_mrs_q  <= 1'b0;
            pend_ref_q <= 1'b0;
            pend_mrs_q <= 1'b0;
            mrs_op_q   <= '0;
            cs_n       <= 1'b1;
            act_n      <= 1'b1;
            ras_n      <= 1'b1;
            cas_n      <= 1'b1;
            we_n       <= 1'b1;
            bg         <= '0;
            ba         <= '0;
            addr       <= '0;
            maint_busy <= 1'b0;
            maint_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_mrs_q  <= sel_mrs_d;
            // If a new pulse coincides with the clear, the new pulse wins and
            // the request is served again.
            pend_ref_q <= (pend_ref_q & ~clr_ref) | refresh_rdy;
            pend_mrs_q <= (pend_mrs_q & ~clr_mrs) | mrs_update_rdy;
            if (mrs_update_rdy) mrs_op_q <= mrs_update_cmd;
            cs_n       <= cs_n_d;
            act_n      <= act_n_d;
            ras_n      <= ras_n_d;
            cas_n      <= cas_n_d;
            we_n       <= we_n_d;
            bg         <= bg_d;
            ba         <= ba_d;
            addr       <= addr_d;
            maint_busy <= (state_d != IDLE);
            maint_done <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_ddr_maint_cmd_seq.sv
// Directed bench for ddr_maint_cmd_seq with default parameters.
// Cycle n is the clock period that follows rising edge n. A request driven
// before edge k is sampled at edge k. Cycle numbers in the checks are
// relative to the scenario's base edge.
module tb_ddr_maint_cmd_seq;

    logic        clock_t = 1'b0;
    logic        reset_n;
    logic        refresh_rdy, mrs_update_rdy;
    logic [17:0] mrs_update_cmd;
    logic        cs_n, act_n, ras_n, cas_n, we_n;
    logic [1:0]  bg, ba;
    logic [17:0] addr;
    logic        maint_busy, maint_done;

`ifdef DDR_MAINT_ZQCS_EN
    localparam int REF_DONE  = 430;  // REF 22 + 280 -> ZQCS 302, + 128
    localparam int RR_DONE2  = 851;  // second refresh: PREA 432, REF 443
`else
    localparam int REF_DONE  = 302;  // REF 22 + 280
    localparam int RR_DONE2  = 595;  // second refresh: PREA 304, REF 315
`endif

    ddr_maint_cmd_seq dut (
        .clock_t        (clock_t),
        .reset_n        (reset_n),
        .refresh_rdy    (refresh_rdy),
        .mrs_update_rdy (mrs_update_rdy),
        .mrs_update_cmd (mrs_update_cmd),
        .cs_n           (cs_n),
        .act_n          (act_n),
        .ras_n          (ras_n),
        .cas_n          (cas_n),
        .we_n           (we_n),
        .bg             (bg),
        .ba             (ba),
        .addr           (addr),
        .maint_busy     (maint_busy),
        .maint_done     (maint_done)
    );

    always #5 clock_t = ~clock_t;

    int cyc = 0;
    always @(posedge clock_t) cyc = cyc + 1;

    // Bus monitor, sampled mid-cycle
    int n_prea = 0, n_ref = 0, n_mrs = 0, n_zq = 0, n_done = 0, n_bad = 0;
    int prea_cyc = 0, ref_cyc = 0, mrs_cyc = 0, zq_cyc = 0, done_cyc = 0;
    logic [17:0] mrs_addr = '0;
    logic [3:0]  mrs_bgba = '0;

    always @(negedge clock_t) begin
        if (cs_n === 1'b0) begin
            case ({act_n, ras_n, cas_n, we_n})
                4'b1010: begin
                    n_prea++; prea_cyc = cyc;
                    if (addr[10] !== 1'b1) n_bad++;
                end
                4'b1001: begin n_ref++; ref_cyc = cyc; end
                4'b1000: begin
                    n_mrs++; mrs_cyc = cyc; mrs_addr = addr; mrs_bgba = {bg, ba};
                end
                4'b1110: begin
                    n_zq++; zq_cyc = cyc;
                    if (addr[10] !== 1'b0) n_bad++;
                end
                default: n_bad++;
            endcase
        end else if (!(cs_n === 1'b1 && act_n === 1'b1 && ras_n === 1'b1 &&
                       cas_n === 1'b1 && we_n === 1'b1 && bg === 2'b00 &&
                       ba === 2'b00 && addr === 18'h0)) begin
            n_bad++;
        end
        if (maint_done === 1'b1) begin n_done++; done_cyc = cyc; end
    end

    int checks = 0, failures = 0;
    int base, d0, r0, m0, p0, z0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clock_t); #1; end
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int i;
        i = 0;
        while (n_done < target && i < budget) begin
            @(posedge clock_t); #1;
            i++;
        end
        check(tag, 32'(n_done >= target), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; refresh_rdy = 1'b0; mrs_update_rdy = 1'b0;
        mrs_update_cmd = '0;
        wait_cycles(3);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_act_n", 32'(act_n), 32'd1);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_busy", 32'(maint_busy), 32'd0);
        check("rst_done", 32'(maint_done), 32'd0);
        reset_n = 1'b1;
        wait_cycles(3);
        check("idle_busy", 32'(maint_busy), 32'd0);

        // Single refresh sampled at edge 10
        d0 = n_done;
        @(posedge clock_t); #1;
        refresh_rdy = 1'b1; base = cyc + 1 - 10;
        @(posedge clock_t); #1;
        refresh_rdy = 1'b0;
        wait_cycles(2);
        check("ref_wait_rp_busy", 32'(maint_busy), 32'd1);
        check("ref_wait_rp_des", 32'(cs_n), 32'd1);
        wait_done("ref_timeout", d0 + 1, 1000);
        check("ref_prea_cyc", 32'(prea_cyc - base), 32'd11);
        check("ref_ref_cyc", 32'(ref_cyc - base), 32'd22);
`ifdef DDR_MAINT_ZQCS_EN
        check("ref_zq_cyc", 32'(zq_cyc - base), 32'd302);
`else
        check("ref_no_zq", 32'(n_zq), 32'd0);
`endif
        check("ref_done_cyc", 32'(done_cyc - base), 32'(REF_DONE));
        check("ref_after_busy", 32'(maint_busy), 32'd0);
        check("ref_after_done", 32'(maint_done), 32'd0);

        // MRS with opcode 0x00A34; the input changes right after the pulse
        wait_cycles(5);
        d0 = n_done;
        @(posedge clock_t); #1;
        mrs_update_rdy = 1'b1; mrs_update_cmd = 18'h00A34; base = cyc + 1 - 10;
        @(posedge clock_t); #1;
        mrs_update_rdy = 1'b0; mrs_update_cmd = 18'h3FFFF;
        wait_done("mrs_timeout", d0 + 1, 200);
        check("mrs_prea_cyc", 32'(prea_cyc - base), 32'd11);
        check("mrs_mrs_cyc", 32'(mrs_cyc - base), 32'd22);
        check("mrs_addr", 32'(mrs_addr), 32'h00A34);
        check("mrs_bgba", 32'(mrs_bgba), 32'd0);
        check("mrs_done_cyc", 32'(done_cyc - base), 32'd46);

        // Both requests in the same cycle: refresh first, one IDLE, then MRS
        wait_cycles(5);
        d0 = n_done; r0 = n_ref; m0 = n_mrs; p0 = n_prea;
        @(posedge clock_t); #1;
        refresh_rdy = 1'b1; mrs_update_rdy = 1'b1; mrs_update_cmd = 18'h12345;
        base = cyc + 1 - 10;
        @(posedge clock_t); #1;
        refresh_rdy = 1'b0; mrs_update_rdy = 1'b0; mrs_update_cmd = '0;
        wait_done("both_timeout1", d0 + 1, 1000);
        check("both_ref_cyc", 32'(ref_cyc - base), 32'd22);
        check("both_done1_cyc", 32'(done_cyc - base), 32'(REF_DONE));
        wait_done("both_timeout2", d0 + 2, 200);
        check("both_prea2_cyc", 32'(prea_cyc - base), 32'(REF_DONE + 2));
        check("both_mrs_cyc", 32'(mrs_cyc - base), 32'(REF_DONE + 13));
        check("both_mrs_addr", 32'(mrs_addr), 32'h12345);
        check("both_done2_cyc", 32'(done_cyc - base), 32'(REF_DONE + 37));
        wait_cycles(60);
        check("both_n_ref", 32'(n_ref - r0), 32'd1);
        check("both_n_mrs", 32'(n_mrs - m0), 32'd1);
        check("both_n_prea", 32'(n_prea - p0), 32'd2);
        check("both_n_done", 32'(n_done - d0), 32'd2);

        // Second refresh at edge 15 (WAIT_RP) gives exactly one extra sequence
        d0 = n_done; r0 = n_ref; p0 = n_prea;
        @(posedge clock_t); #1;
        refresh_rdy = 1'b1; base = cyc + 1 - 10;
        @(posedge clock_t); #1;
        refresh_rdy = 1'b0;
        wait_cycles(4);
        refresh_rdy = 1'b1;
        @(posedge clock_t); #1;
        refresh_rdy = 1'b0;
        wait_done("rr_timeout", d0 + 2, 2000);
        check("rr_prea2_cyc", 32'(prea_cyc - base), 32'(REF_DONE + 2));
        check("rr_ref2_cyc", 32'(ref_cyc - base), 32'(REF_DONE + 13));
        check("rr_done2_cyc", 32'(done_cyc - base), 32'(RR_DONE2));
        wait_cycles(500);
        check("rr_n_ref", 32'(n_ref - r0), 32'd2);
        check("rr_n_prea", 32'(n_prea - p0), 32'd2);
        check("rr_n_done", 32'(n_done - d0), 32'd2);

        // Reset during WAIT_RFC; a pulse while in reset is ignored
        @(posedge clock_t); #1;
        refresh_rdy = 1'b1; base = cyc + 1 - 10;
        @(posedge clock_t); #1;
        refresh_rdy = 1'b0;
        wait_cycles(90);
        check("rst_mid_busy_before", 32'(maint_busy), 32'd1);
        r0 = n_ref; z0 = n_zq; p0 = n_prea; d0 = n_done;
        reset_n = 1'b0;
        #1;
        check("rst_mid_cs_n", 32'(cs_n), 32'd1);
        check("rst_mid_busy", 32'(maint_busy), 32'd0);
        wait_cycles(1);
        refresh_rdy = 1'b1;
        wait_cycles(1);
        refresh_rdy = 1'b0;
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(500);
        check("rst_mid_n_ref", 32'(n_ref - r0), 32'd0);
        check("rst_mid_n_zq", 32'(n_zq - z0), 32'd0);
        check("rst_mid_n_prea", 32'(n_prea - p0), 32'd0);
        check("rst_mid_n_done", 32'(n_done - d0), 32'd0);
        check("rst_mid_busy_after", 32'(maint_busy), 32'd0);

        check("bus_encoding_errors", 32'(n_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
